multiplexor_display: RTL and testbench
======================================

Name: multiplexor_display

Overview:
- Time-multiplexed scan driver for an N-digit common-anode 7-segment display.
- Holds a packed BCD word and presents one digit at a time on cifraBCD. cifraBCD feeds the downstream BCD-to-7-segment converter, which maps 0-9 to segments and any other code to all-off.
- Drives the active-low anode lines, inserts an anti-ghosting blank window at each digit change, and applies new values only at frame boundaries so the display never tears.

Parameters:
- N_DIGITOS, 4, number of digits scanned (2..8).
- PRESCALER, 50000, clk cycles per digit slot (≥ BLANK_CICLOS+2).
- BLANK_CICLOS, 2, cycles at the start of each slot with all anodes off (0 disables blanking).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- cargar  input  1  one-cycle load strobe for valorBCD/puntosIn.
- valorBCD  input  4*N_DIGITOS  packed BCD digits; digit 0 = bits [3:0] = least significant (rightmost).
- puntosIn  input  N_DIGITOS  decimal-point enables, bit i belongs to digit i.
- cifraBCD  output  4  BCD code of the digit currently scanned (to the converter).
- punto  output  1  active-low decimal point for the current digit.
- anodos  output  N_DIGITOS  active-low digit enables; at most one bit low at any time.
- finTrama  output  1  one-cycle pulse at each frame wrap (last digit -> digit 0).
- pendiente  output  1  high while a loaded value waits for the frame boundary.

Behaviour:
- Single clock domain; reset synchronous, active-high. All state and outputs are registered.
- Reset values:
  - cnt=0, idx=0
  - display and shadow registers all 4'hF (blank), dot registers all 0
  - anodos all 1s, cifraBCD=4'hF, punto=1, finTrama=0, pendiente=0
- Prescaler:
  - cnt counts 0..PRESCALER-1 and wraps to 0.
  - tick = (cnt==PRESCALER-1).
  - On tick, idx advances; idx==N_DIGITOS-1 wraps to 0.
- Outputs each cycle reflect the post-edge values of cnt/idx, so there is no extra latency between state and pins:
  - anodos = all 1s while cnt < BLANK_CICLOS; otherwise only bit idx is 0.
  - cifraBCD = display digit idx.
  - punto = ~dot[idx].
- Load:
  - cargar=1 -> shadow <= valorBCD, shadow dots <= puntosIn, pendiente <= 1.
  - A second cargar before the boundary overwrites the shadow (last write wins).
- Frame boundary (tick with idx==N_DIGITOS-1):
  - finTrama=1 for that cycle.
  - If pendiente: display <= shadow, pendiente <= 0.
  - Digit 0 of the new frame already shows the new value.
- cargar coincident with the boundary: valorBCD goes straight to display (bypass), pendiente stays 0.
- Non-BCD digits (A-F) pass through unmodified; the converter blanks them.
- reset asserted mid-frame or mid-blank: everything returns to reset values on the next edge, and any pending load is discarded.

Optional Feature:
- Macro SUPRIMIR_CEROS_EN (leading-zero blanking).
- Defined:
  - A digit i>0 outputs cifraBCD=4'hF when it and every more-significant display digit equal 0.
  - Digit 0 is never suppressed.
  - A suppressed digit's dot still follows dot[i].
  - Suppression is computed from the display register, not the shadow.
- Undefined: all digits are shown verbatim, including zeros.

Decomposition:
- Shared package/include (definiciones.vh): BCD_BLANCO=4'hF, ANODOS_OFF pattern macro, default PRESCALER/BLANK_CICLOS.
- One natural sub-module, divisor_refresco: parametrised prescaler counter emitting tick and cnt.
- Scan/latch logic stays in the top module.

Test Plan:
- Common settings for all cases: N_DIGITOS=4, PRESCALER=8, BLANK_CICLOS=2.
- Reset release:
  - Stimulus: no cargar for 40 cycles.
  - Expected: cifraBCD=4'hF in every slot; anodos sequence 1111,1111,1110×6, 1111,1111,1101×6, …
  - Expected: finTrama pulses every 32 cycles.
- Load 16'h1234, puntosIn=4'b0100 mid-frame:
  - pendiente=1 until the boundary; old digits shown until then.
  - Next frame: slots 0..3 show 4,3,2,1; punto=0 only in slot 2.
- Two cargar strobes in one frame (16'h1111 then 16'h9876): the next frame shows 6,7,8,9 and 1111 is never displayed.
- cargar 16'h0555 exactly on the boundary cycle: pendiente stays 0; slot 0 of the new frame shows 5.
- With SUPRIMIR_CEROS_EN, load 16'h0007: slots 3,2,1 show 4'hF, slot 0 shows 7.
- With SUPRIMIR_CEROS_EN, load 16'h0000: slot 0 shows 0.
- Reset asserted at cnt=5, idx=2 with a pending load: next edge gives all reset values and pendiente=0; the following frame shows blanks.

Source files
------------

// File: rtl/multiplexor_display_pkg.sv
// ---------------------------------------------------------------------------
// multiplexor_display_pkg
// Shared constants for the 7-segment scan driver:
//   BCD_BLANCO        code the BCD-to-7-segment converter renders as all-off
//   PRESCALER_DEF     default clk cycles per digit slot
//   BLANK_CICLOS_DEF  default anti-ghosting blank window per slot
//   N_DIGITOS_DEF     default number of scanned digits
// The "anodes off" pattern is all ones at whatever digit count the top is
// built with, so it lives in the top as ANODOS_OFF.
// ---------------------------------------------------------------------------
package multiplexor_display_pkg;

    localparam logic [3:0] BCD_BLANCO       = 4'hF;
    localparam int         PRESCALER_DEF    = 50000;
    localparam int         BLANK_CICLOS_DEF = 2;
    localparam int         N_DIGITOS_DEF    = 4;

endpackage

// File: rtl/multiplexor_display_divisor_refresco.sv
// ---------------------------------------------------------------------------
// multiplexor_display_divisor_refresco
// Refresh prescaler: counts 0..PRESCALER-1 and wraps.
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high reset (count returns to 0)
//   tick_o   out  high while the count sits at PRESCALER-1 (slot ends this edge)
//   cnt_d_o  out  value the count takes at the next edge; the top registers
//                 its outputs from this so pins track the post-edge state
// ---------------------------------------------------------------------------
module multiplexor_display_divisor_refresco #(
    parameter int PRESCALER = 50000,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    output logic             tick_o,
    output logic [CNT_W-1:0] cnt_d_o
);

    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        tick_o  = (cnt_q == CNT_W'(PRESCALER - 1));
        cnt_d_o = tick_o ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d_o;
        end
    end

endmodule

// File: rtl/multiplexor_display.sv
// ---------------------------------------------------------------------------
// multiplexor_display
// Time-multiplexed scan driver for an N-digit common-anode 7-segment display.
// One digit at a time is presented on cifraBCD with its active-low anode;
// each slot starts with a blank window (all anodes off) against ghosting, and
// new values are latched only at frame boundaries so the display never tears.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   cargar     in   one-cycle load strobe for valorBCD/puntosIn
//   valorBCD   in   packed BCD, digit 0 = bits [3:0] = rightmost
//   puntosIn   in   decimal-point enables, bit i belongs to digit i
//   cifraBCD   out  BCD code of the digit being scanned
//   punto      out  active-low decimal point of the digit being scanned
//   anodos     out  active-low digit enables, at most one low
//   finTrama   out  one-cycle pulse on each frame wrap (last digit -> 0)
//   pendiente  out  high while a loaded value waits for the frame boundary
//
// Build option: define SUPRIMIR_CEROS_EN for leading-zero blanking (digits
// above 0 that are zero together with every more-significant digit are sent
// as BCD_BLANCO; their decimal point still follows the dot register).
// ---------------------------------------------------------------------------
module multiplexor_display
    import multiplexor_display_pkg::*;
#(
    parameter int N_DIGITOS    = N_DIGITOS_DEF,
    parameter int PRESCALER    = PRESCALER_DEF,
    parameter int BLANK_CICLOS = BLANK_CICLOS_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cargar,
    input  logic [4*N_DIGITOS-1:0] valorBCD,
    input  logic [N_DIGITOS-1:0]   puntosIn,
    output logic [3:0]             cifraBCD,
    output logic                   punto,
    output logic [N_DIGITOS-1:0]   anodos,
    output logic                   finTrama,
    output logic                   pendiente
);

    localparam int IDX_W = $clog2(N_DIGITOS);
    localparam int CNT_W = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;
    localparam logic [N_DIGITOS-1:0] ANODOS_OFF = '1;
    localparam logic [N_DIGITOS-1:0] UNO        = N_DIGITOS'(1);

    logic             tick;
    logic [CNT_W-1:0] cnt_d;

    multiplexor_display_divisor_refresco #(
        .PRESCALER (PRESCALER),
        .CNT_W     (CNT_W)
    ) u_divisor_refresco (
        .clk     (clk),
        .reset   (reset),
        .tick_o  (tick),
        .cnt_d_o (cnt_d)
    );

    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [3:0]           disp_q [N_DIGITOS];
    logic [3:0]           disp_d [N_DIGITOS];
    logic [3:0]           sombra_q [N_DIGITOS];
    logic [3:0]           sombra_d [N_DIGITOS];
    logic [3:0]           entrada [N_DIGITOS];
    logic [N_DIGITOS-1:0] puntos_q, puntos_d;
    logic [N_DIGITOS-1:0] sombra_pts_q, sombra_pts_d;
    logic                 pend_q, pend_d;
    logic [N_DIGITOS-1:0] anodos_q, anodos_d;
    logic [3:0]           cifra_q, cifra_d;
    logic                 punto_q, punto_d;
    logic                 fin_q, fin_d;
    logic                 idx_ult;
    logic                 frontera;

    always_comb begin
        for (int i = 0; i < N_DIGITOS; i++) begin
            entrada[i] = valorBCD[4*i +: 4];
        end
    end

    // Next-state: scan index and display/shadow latching
    always_comb begin
        idx_ult  = (idx_q == IDX_W'(N_DIGITOS - 1));
        frontera = tick && idx_ult;

        idx_d = idx_q;
        if (tick) begin
            idx_d = idx_ult ? '0 : idx_q + 1'b1;
        end

        disp_d       = disp_q;
        puntos_d     = puntos_q;
        sombra_d     = sombra_q;
        sombra_pts_d = sombra_pts_q;
        pend_d       = pend_q;

        if (frontera) begin
            pend_d = 1'b0;
            if (cargar) begin
                // Load on the boundary itself goes straight to the display.
                disp_d   = entrada;
                puntos_d = puntosIn;
            end else if (pend_q) begin
                disp_d   = sombra_q;
                puntos_d = sombra_pts_q;
            end
        end else if (cargar) begin
            sombra_d     = entrada;
            sombra_pts_d = puntosIn;
            pend_d       = 1'b1;
        end
    end

    // Registered outputs are derived from the post-edge count, index and
    // display contents so the pins carry no extra cycle of latency.
    always_comb begin
        fin_d   = frontera;
        punto_d = ~puntos_d[idx_d];
        cifra_d = disp_d[idx_d];

        if (cnt_d < CNT_W'(BLANK_CICLOS)) begin
            anodos_d = ANODOS_OFF;
        end else begin
            anodos_d = ~(UNO << idx_d);
        end

`ifdef SUPRIMIR_CEROS_EN
        begin : supresion
            logic                 todo_cero;
            logic [N_DIGITOS-1:0] suprimir;
            // Walk from the most significant digit down; digit 0 is never
            // included, so a zero value still shows a single 0.
            todo_cero = 1'b1;
            suprimir  = '0;
            for (int i = N_DIGITOS - 1; i > 0; i--) begin
                todo_cero   = todo_cero && (disp_d[i] == 4'h0);
                suprimir[i] = todo_cero;
            end
            if (suprimir[idx_d]) begin
                cifra_d = BCD_BLANCO;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q        <= '0;
            pend_q       <= 1'b0;
            puntos_q     <= '0;
            sombra_pts_q <= '0;
            anodos_q     <= ANODOS_OFF;
            cifra_q      <= BCD_BLANCO;
            punto_q      <= 1'b1;
            fin_q        <= 1'b0;
            for (int i = 0; i < N_DIGITOS; i++) begin
                disp_q[i]   <= BCD_BLANCO;
                sombra_q[i] <= BCD_BLANCO;
            end
        end else begin
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            puntos_q     <= puntos_d;
            sombra_pts_q <= sombra_pts_d;
            anodos_q     <= anodos_d;
            cifra_q      <= cifra_d;
            punto_q      <= punto_d;
            fin_q        <= fin_d;
            disp_q       <= disp_d;
            sombra_q     <= sombra_d;
        end
    end

    assign cifraBCD  = cifra_q;
    assign punto     = punto_q;
    assign anodos    = anodos_q;
    assign finTrama  = fin_q;
    assign pendiente = pend_q;

endmodule

// File: tb/tb_multiplexor_display.sv
// ---------------------------------------------------------------------------
// tb_multiplexor_display
// Directed bench for the scan driver with N_DIGITOS=4, PRESCALER=8,
// BLANK_CICLOS=2 (one frame = 32 cycles). The bench tracks the frame
// position (idx*8 + cnt) and the digits the display should be holding,
// and checks every pin on every cycle.
// ---------------------------------------------------------------------------
module tb_multiplexor_display;

    logic        clk;
    logic        reset;
    logic        cargar;
    logic [15:0] valorBCD;
    logic [3:0]  puntosIn;
    logic [3:0]  cifraBCD;
    logic        punto;
    logic [3:0]  anodos;
    logic        finTrama;
    logic        pendiente;

    multiplexor_display #(
        .N_DIGITOS    (4),
        .PRESCALER    (8),
        .BLANK_CICLOS (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cargar    (cargar),
        .valorBCD  (valorBCD),
        .puntosIn  (puntosIn),
        .cifraBCD  (cifraBCD),
        .punto     (punto),
        .anodos    (anodos),
        .finTrama  (finTrama),
        .pendiente (pendiente)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp;
    int          n_mis;
    int          pos;        // idx*8 + cnt of the DUT after the last edge
    logic [15:0] cur_val;    // digits the display holds
    logic [3:0]  cur_dots;
    logic [15:0] nxt_val;    // digits waiting for the frame boundary
    logic [3:0]  nxt_dots;
    logic        exp_pend;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h pos=%0d", tag, obs, expv, pos);
        end
    endtask

    function automatic logic [3:0] exp_anod(input int p);
        logic [3:0] a;
        if ((p % 8) < 2) a = 4'hF;
        else             a = ~(4'b0001 << (p / 8));
        return a;
    endfunction

    function automatic logic [3:0] exp_cifra(input int s);
        logic [3:0] dg;
        logic       todo0;
        dg    = cur_val[4*s +: 4];
        todo0 = 1'b1;
`ifdef SUPRIMIR_CEROS_EN
        for (int j = s; j < 4; j++) begin
            if (cur_val[4*j +: 4] != 4'h0) todo0 = 1'b0;
        end
        if (s > 0 && todo0) dg = 4'hF;
`else
        todo0 = 1'b0;
        if (todo0) dg = 4'hF;
`endif
        return dg;
    endfunction

    // One clock edge with optional load, then check every output.
    task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d);
        logic [3:0] e_an;
        logic [3:0] e_cf;
        logic       e_pt;
        logic       e_fin;
        cargar   = ld;
        valorBCD = v;
        puntosIn = d;
        @(posedge clk);
        #1;
        cargar = 1'b0;
        pos    = (pos + 1) % 32;
        if (pos == 0) begin
            if (ld) begin
                cur_val  = v;
                cur_dots = d;
            end else if (exp_pend) begin
                cur_val  = nxt_val;
                cur_dots = nxt_dots;
            end
            exp_pend = 1'b0;
        end else if (ld) begin
            nxt_val  = v;
            nxt_dots = d;
            exp_pend = 1'b1;
        end
        e_an  = exp_anod(pos);
        e_cf  = exp_cifra(pos / 8);
        e_pt  = ~cur_dots[pos / 8];
        e_fin = (pos == 0);
        chk("anodos",    {12'h0, anodos},    {12'h0, e_an});
        chk("cifraBCD",  {12'h0, cifraBCD},  {12'h0, e_cf});
        chk("punto",     {15'h0, punto},     {15'h0, e_pt});
        chk("finTrama",  {15'h0, finTrama},  {15'h0, e_fin});
        chk("pendiente", {15'h0, pendiente}, {15'h0, exp_pend});
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b0, 16'h0, 4'h0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_anodos"},    {12'h0, anodos},    16'h000F);
        chk({tag, "_cifraBCD"},  {12'h0, cifraBCD},  16'h000F);
        chk({tag, "_punto"},     {15'h0, punto},     16'h0001);
        chk({tag, "_finTrama"},  {15'h0, finTrama},  16'h0000);
        chk({tag, "_pendiente"}, {15'h0, pendiente}, 16'h0000);
    endtask

    initial begin
        n_cmp    = 0;
        n_mis    = 0;
        pos      = 0;
        cur_val  = 16'hFFFF;
        cur_dots = 4'h0;
        nxt_val  = 16'hFFFF;
        nxt_dots = 4'h0;
        exp_pend = 1'b0;
        reset    = 1'b1;
        cargar   = 1'b0;
        valorBCD = 16'h0;
        puntosIn = 4'h0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_reset_state("rst");
        reset = 1'b0;

        // Idle after release: blanks, anode sequence, finTrama every 32
        run(40);                              // ends at pos 8

        // Mid-frame load of 1234 with dot on digit 2
        step(1'b1, 16'h1234, 4'b0100);        // pos 9, pendiente high
        run(55);                              // through the next full frame, pos 0
        run(1);                               // pos 1

        // Two loads in one frame: last one wins
        step(1'b1, 16'h1111, 4'b0000);        // pos 2
        run(5);                               // pos 7
        step(1'b1, 16'h9876, 4'b0000);        // pos 8
        run(56);                              // pos 0, 9876 frame fully checked

        // Load exactly on the boundary cycle: bypass, pendiente stays low
        run(31);                              // pos 31
        step(1'b1, 16'h0555, 4'b0000);        // pos 0, slot 0 shows 5
        chk("bypass_pendiente", {15'h0, pendiente}, 16'h0000);
        chk("bypass_slot0",     {12'h0, cifraBCD},  16'h0005);
        run(32);                              // pos 0

        // Leading zeros (suppressed only when the option is built in)
        step(1'b1, 16'h0007, 4'b0010);        // pos 1
        run(63);                              // pos 0
        step(1'b1, 16'h0000, 4'b0000);        // pos 1
        run(63);                              // pos 0

        // Reset at cnt=5, idx=2 with a load pending
        run(20);                              // pos 20
        step(1'b1, 16'h4321, 4'b1111);        // pos 21, pending
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        pos      = 0;
        cur_val  = 16'hFFFF;
        cur_dots = 4'h0;
        exp_pend = 1'b0;
        chk_reset_state("midrst");
        run(40);                              // pending load discarded: blanks

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
